// File: rtl/ram_dump_streamer.sv
// Reads base_addr..base_addr+length-1 from the RAM scalar port and streams each byte over valid/ready.
// Optional trailing XOR checksum byte is compiled in when DUMP_CHECKSUM_EN is defined.
module ram_dump_streamer #(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd4;
`endif
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    data_d  = data_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = length;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = (length != '0) ? S_ISSUE : S_FIN;
        end
      end
      S_ISSUE: begin
        lat_d   = 2'(RAM_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ram_q is valid only on the final wait cycle
        if (lat_q <= 2'd1) begin
          data_d  = ram_q;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
          if (rem_q == ADDR_W'(1)) begin
            data_d  = csum_q ^ data_q;
            state_d = S_CSUM;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = (rem_q == ADDR_W'(1)) ? S_FIN : S_ISSUE;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (out_ready) state_d = S_FIN;
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode registered state only, so out_ready never reaches them combinationally
  assign ram_address = addr_q;
  assign ram_rden    = (state_q == S_ISSUE);
  assign out_data    = data_q;
`ifdef DUMP_CHECKSUM_EN
  assign out_valid   = (state_q == S_SEND) || (state_q == S_CSUM);
  assign out_last    = (state_q == S_CSUM);
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_SEND)  || (state_q == S_CSUM);
`else
  assign out_valid   = (state_q == S_SEND);
  assign out_last    = (state_q == S_SEND) && (rem_q == ADDR_W'(1));
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SEND);
`endif
  assign done        = (state_q == S_FIN);

endmodule
